// File: rtl/debug_master.sv
// debug_master: issues one debug-port read or write per host command and returns the result or a timeout error.
// Ports: clk_i/rst_ni clock and synchronous active-low reset.
// cmd_* is the host command channel (valid/ready, we, addr, wdata).
// rsp_* is the response channel (valid/ready, rdata, err, we echo).
// debug_* is the request/grant/rvalid initiator side of the core debug port.
// busy_o is high whenever a transaction is in flight.
module debug_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]           cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_we_o,
    output logic                  debug_req_o,
    input  logic                  debug_gnt_i,
    input  logic                  debug_rvalid_i,
    output logic [ADDR_WIDTH-1:0] debug_addr_o,
    output logic                  debug_we_o,
    output logic [31:0]           debug_wdata_o,
    input  logic [31:0]           debug_rdata_i,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;
    state_e                state_q;
    logic [TO_WIDTH-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  rsp_we_q;
    logic                  expire;
    // Each handshake phase spends exactly TIMEOUT cycles before giving up.
    assign expire = cnt_q == TO_WIDTH'(TIMEOUT - 1);
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rsp_we_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid_i) begin
                    addr_q  <= cmd_addr_i;
                    we_q    <= cmd_we_i;
                    wdata_q <= cmd_wdata_i;
                    cnt_q   <= '0;
                    state_q <= REQ;
                end
                REQ: if (debug_gnt_i) begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end else if (expire) begin
                    rdata_q  <= '0;
                    err_q    <= 1'b1;
                    rsp_we_q <= we_q;
                    state_q  <= RSP;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + TO_WIDTH'(1);
                end
                WAIT: if (debug_rvalid_i) begin
                    rdata_q  <= we_q ? 32'h0 : debug_rdata_i;
                    err_q    <= 1'b0;
                    rsp_we_q <= we_q;
                    state_q  <= RSP;
                end else if (expire) begin
                    rdata_q  <= '0;
                    err_q    <= 1'b1;
                    rsp_we_q <= we_q;
                    state_q  <= RSP;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + TO_WIDTH'(1);
                end
                RSP: if (rsp_ready_i) state_q <= IDLE;
            endcase
        end
    end
    assign cmd_ready_o   = state_q == IDLE;
    assign busy_o        = state_q != IDLE;
    assign debug_req_o   = state_q == REQ;
    assign rsp_valid_o   = state_q == RSP;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_we_o      = rsp_we_q;
    assign debug_addr_o  = addr_q;
    assign debug_we_o    = we_q;
    assign debug_wdata_o = wdata_q;
endmodule

// File: tb/tb_debug_master.sv
// tb_debug_master: randomized scoreboard bench for debug_master with a behavioural responder model.
module tb_debug_master;
    localparam int T = 4;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_we_i = 1'b0;
    logic [14:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        rsp_ready_i = 1'b0;
    logic        debug_gnt_i = 1'b0;
    logic        debug_rvalid_i = 1'b0;
    logic [31:0] debug_rdata_i = '0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_we_o, debug_req_o, debug_we_o, busy_o;
    logic [31:0] rsp_rdata_o, debug_wdata_o;
    logic [14:0] debug_addr_o;
    int errors = 0;
    int checks = 0;
    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;

    debug_master #(.ADDR_WIDTH(15), .TIMEOUT(T), .TO_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
        .debug_req_o(debug_req_o), .debug_gnt_i(debug_gnt_i), .debug_rvalid_i(debug_rvalid_i),
        .debug_addr_o(debug_addr_o), .debug_we_o(debug_we_o), .debug_wdata_o(debug_wdata_o),
        .debug_rdata_i(debug_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endfunction

    function automatic void chk_reset();
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_req", debug_req_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_rsp_we", rsp_we_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        chk("rst_dbg_addr", debug_addr_o, 0);
        chk("rst_dbg_we", debug_we_o, 0);
        chk("rst_dbg_wdata", debug_wdata_o, 0);
        chk("rst_busy", busy_o, 0);
    endfunction

    // Monitor: pops one expected response per observed response handshake.
    always @(negedge clk_i) begin
        #1;
        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                chk("rsp_err", rsp_err_o, 32'(mon_e.err));
                chk("rsp_we", rsp_we_o, 32'(mon_e.we));
            end
        end
    end

    // g: REQ cycles before grant (>=T means never); r: WAIT cycles before rvalid; bp: response stall cycles.
    task automatic txn(input logic we, input logic [14:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int g, input int r, input int bp);
        rsp_t e;
        bit   to;
        to = (g >= T) || (r >= T);
        e.we = we;
        e.err = to;
        e.rdata = (to || we) ? 32'h0 : rd;
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i = we;
        cmd_addr_i = a;
        cmd_wdata_i = wd;
        exp_q.push_back(e);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_we_i = ~we;
        cmd_addr_i = ~a;
        cmd_wdata_i = ~wd;
        for (int i = 0; i < T; i++) begin
            chk("req_high", debug_req_o, 1);
            chk("req_addr", debug_addr_o, a);
            chk("req_we", debug_we_o, we);
            chk("req_wdata", debug_wdata_o, wd);
            chk("req_cmd_ready", cmd_ready_o, 0);
            chk("req_no_rsp", rsp_valid_o, 0);
            debug_rvalid_i = 1'($urandom);
            if (i == g) debug_gnt_i = 1'b1;
            @(negedge clk_i);
            debug_gnt_i = 1'b0;
            debug_rvalid_i = 1'b0;
            if (i == g) break;
        end
        if (g < T) begin
            for (int j = 0; j < T; j++) begin
                chk("wait_req_low", debug_req_o, 0);
                chk("wait_no_rsp", rsp_valid_o, 0);
                chk("wait_busy", busy_o, 1);
                if (j == r) begin
                    debug_rvalid_i = 1'b1;
                    debug_rdata_i = rd;
                end else debug_gnt_i = 1'($urandom);
                @(negedge clk_i);
                debug_rvalid_i = 1'b0;
                debug_gnt_i = 1'b0;
                debug_rdata_i = $urandom;
                if (j == r) break;
            end
        end
        chk("rsp_valid", rsp_valid_o, 1);
        chk("rsp_req_low", debug_req_o, 0);
        for (int k = 0; k < bp; k++) begin
            chk("bp_valid", rsp_valid_o, 1);
            chk("bp_cmd_ready", cmd_ready_o, 0);
            chk("bp_rdata", rsp_rdata_o, e.rdata);
            chk("bp_err", rsp_err_o, 32'(e.err));
            chk("bp_we", rsp_we_o, 32'(e.we));
            debug_rvalid_i = 1'($urandom);
            debug_gnt_i = 1'($urandom);
            @(negedge clk_i);
            debug_rvalid_i = 1'b0;
            debug_gnt_i = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("idle_cmd_ready", cmd_ready_o, 1);
        chk("idle_busy", busy_o, 0);
        chk("idle_rsp_valid", rsp_valid_o, 0);
        chk("idle_addr_hold", debug_addr_o, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        chk_reset();
        rst_ni = 1'b1;
        @(negedge clk_i);
        txn(1'b0, 15'h0100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
        txn(1'b1, 15'h2000, 32'h12345678, 32'hCAFEF00D, 3, 0, 0);
        txn(1'b0, 15'h0ABC, 32'h0, 32'h0BADF00D, 1, 1, 5);
        txn(1'b1, 15'h1234, 32'hA5A5A5A5, 32'h11111111, T, 0, 1);
        txn(1'b0, 15'h0042, 32'h0, 32'h76543210, 0, 0, 0);
        txn(1'b0, 15'h7FFF, 32'h0, 32'h89ABCDEF, T - 1, 0, 0);
        txn(1'b0, 15'h0007, 32'h0, 32'h13579BDF, 0, T - 1, 0);
        txn(1'b0, 15'h0008, 32'h0, 32'h2468ACE0, 2, T, 2);
        // Reset while waiting for rvalid: transaction must vanish without a response.
        cmd_valid_i = 1'b1;
        cmd_we_i = 1'b0;
        cmd_addr_i = 15'h0055;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        debug_gnt_i = 1'b1;
        @(negedge clk_i);
        debug_gnt_i = 1'b0;
        chk("pre_rst_busy", busy_o, 1);
        chk("pre_rst_req_low", debug_req_o, 0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        debug_rvalid_i = 1'b1;
        debug_rdata_i = 32'hFFFFFFFF;
        chk_reset();
        @(negedge clk_i);
        debug_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_rsp", rsp_valid_o, 0);
            chk("post_rst_ready", cmd_ready_o, 1);
            @(negedge clk_i);
        end
        for (int n = 0; n < 60; n++)
            txn(1'($urandom), 15'($urandom), $urandom, $urandom,
                int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 1)),
                int'($urandom_range(0, 3)));
        repeat (3) @(negedge clk_i);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
